// File: rtl/floppy_dsk_fetch.sv
// ============================================================================
// Module   : floppy_dsk_fetch
// Purpose  : Round-robin disk-image byte fetcher for two floppy drives, with a
//            one-word read buffer per drive in front of word-wide memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floppy_dsk_fetch #(
  parameter logic [23:0] BASE_INT = 24'h000000,
  parameter logic [23:0] BASE_EXT = 24'h100000
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [21:0] dskReadAddrInt,
  output logic        dskReadAckInt,
  input  logic [21:0] dskReadAddrExt,
  output logic        dskReadAckExt,
  output logic [7:0]  dskReadData,
  output logic        memReq,
  output logic [23:0] memAddr,
  input  logic        memAck,
  input  logic [15:0] memData
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t           state_q;
  logic             sel_q;
  logic [21:0]      addr_q;
  logic [1:0][21:0] lastAddr_q;
  logic [1:0]       lastValid_q;
  logic [1:0][20:0] bufTag_q;
  logic [1:0][15:0] bufWord_q;
  logic [1:0]       bufValid_q;
  logic             rrLast_q;
  logic             memReq_q;
  logic [23:0]      memAddr_q;
  logic [7:0]       data_q;
  logic             ackInt_q;
  logic             ackExt_q;

  logic [1:0]       pend;
  logic             sel_d;
  logic [21:0]      addr_d;
  logic             hit_d;
  logic [7:0]       hitByte_d;
  logic [23:0]      missAddr_d;
  logic [7:0]       memByte_d;

  // A drive is pending until its current address has been granted once.
  assign pend[0] = !lastValid_q[0] || (dskReadAddrInt != lastAddr_q[0]);
  assign pend[1] = !lastValid_q[1] || (dskReadAddrExt != lastAddr_q[1]);

  assign sel_d      = (pend[0] && pend[1]) ? ~rrLast_q : pend[1];
  assign addr_d     = sel_d ? dskReadAddrExt : dskReadAddrInt;
  assign hit_d      = bufValid_q[sel_d] && (bufTag_q[sel_d] == addr_d[21:1]);
  assign hitByte_d  = addr_d[0] ? bufWord_q[sel_d][7:0] : bufWord_q[sel_d][15:8];
  assign missAddr_d = (sel_d ? BASE_EXT : BASE_INT) + {3'b000, addr_d[21:1]};
  assign memByte_d  = addr_q[0] ? memData[7:0] : memData[15:8];

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      lastAddr_q  <= '0;
      lastValid_q <= '0;
      bufTag_q    <= '0;
      bufWord_q   <= '0;
      bufValid_q  <= '0;
      rrLast_q    <= 1'b1;
      memReq_q    <= 1'b0;
      memAddr_q   <= '0;
      data_q      <= '0;
      ackInt_q    <= 1'b0;
      ackExt_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend[0] || pend[1]) begin
            sel_q              <= sel_d;
            addr_q             <= addr_d;
            lastAddr_q[sel_d]  <= addr_d;
            lastValid_q[sel_d] <= 1'b1;
            rrLast_q           <= sel_d;
            if (hit_d) begin
              data_q   <= hitByte_d;
              ackInt_q <= ~sel_d;
              ackExt_q <= sel_d;
              state_q  <= S_DELIVER;
            end else begin
              memAddr_q <= missAddr_d;
              memReq_q  <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (memAck) begin
            memReq_q          <= 1'b0;
            bufWord_q[sel_q]  <= memData;
            bufTag_q[sel_q]   <= addr_q[21:1];
            bufValid_q[sel_q] <= 1'b1;
            data_q            <= memByte_d;
            ackInt_q          <= ~sel_q;
            ackExt_q          <= sel_q;
            state_q           <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          ackInt_q <= 1'b0;
          ackExt_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          ackInt_q <= 1'b0;
          ackExt_q <= 1'b0;
          memReq_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign dskReadAckInt = ackInt_q;
  assign dskReadAckExt = ackExt_q;
  assign dskReadData   = data_q;
  assign memReq        = memReq_q;
  assign memAddr       = memAddr_q;

endmodule

`default_nettype wire

// File: tb/tb_floppy_dsk_fetch.sv
// ============================================================================
// Module   : tb_floppy_dsk_fetch
// Purpose  : Self-checking bench for floppy_dsk_fetch with a behavioural
//            memory responder and a transaction-level drive/buffer model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floppy_dsk_fetch;

  localparam logic [23:0] BASE_INT = 24'h000000;
  localparam logic [23:0] BASE_EXT = 24'h100000;

  logic        clk;
  logic        _reset;
  logic [21:0] dskReadAddrInt;
  logic        dskReadAckInt;
  logic [21:0] dskReadAddrExt;
  logic        dskReadAckExt;
  logic [7:0]  dskReadData;
  logic        memReq;
  logic [23:0] memAddr;
  logic        memAck;
  logic [15:0] memData;

  int n_checks;
  int n_fail;

  bit          resp_en;
  bit          rnd_delay;
  int          fixed_delay;
  bit          inject;
  logic [23:0] req_log[$];

  floppy_dsk_fetch #(.BASE_INT(BASE_INT), .BASE_EXT(BASE_EXT)) dut (
    .clk(clk), ._reset(_reset),
    .dskReadAddrInt(dskReadAddrInt), .dskReadAckInt(dskReadAckInt),
    .dskReadAddrExt(dskReadAddrExt), .dskReadAckExt(dskReadAckExt),
    .dskReadData(dskReadData),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Disk image contents: two fixed words, everything else a simple hash.
  function automatic logic [15:0] mem_word(input logic [23:0] a);
    if (a == 24'h000000) return 16'hA5C3;
    if (a == 24'h100002) return 16'h1234;
    return {a[7:0] ^ 8'h3C, a[15:8] ^ a[23:16] ^ 8'h96};
  endfunction

  function automatic logic [23:0] word_addr(input int d, input logic [21:0] a);
    return (d == 1 ? BASE_EXT : BASE_INT) + {3'b000, a[21:1]};
  endfunction

  function automatic logic [7:0] exp_byte(input int d, input logic [21:0] a);
    logic [15:0] w;
    w = mem_word(word_addr(d, a));
    return a[0] ? w[7:0] : w[15:8];
  endfunction

  // Memory responder: acks a held request after a fixed or random delay.
  initial begin
    int cnt;
    int tgt;
    memAck = 1'b0; memData = '0; cnt = 0; tgt = 0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (inject) begin
        memAck  = 1'b1;
        memData = 16'hDEAD;
        inject  = 1'b0;
      end else if (resp_en && memReq && _reset) begin
        if (cnt == 0) tgt = rnd_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        if (cnt >= tgt) begin
          memAck  = 1'b1;
          memData = mem_word(memAddr);
          req_log.push_back(memAddr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // kind: 0 none (timeout), 1 Int, 2 Ext, 3 both.
  task automatic wait_ack(input int maxc, output int kind, output logic [7:0] data, output int cyc);
    kind = 0; data = '0; cyc = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (dskReadAckInt || dskReadAckExt) begin
        kind = (dskReadAckInt ? 1 : 0) + (dskReadAckExt ? 2 : 0);
        data = dskReadData;
        cyc  = i;
        break;
      end
    end
  endtask

  task automatic start(input logic [21:0] ai, input logic [21:0] ae, input int dly);
    _reset = 1'b0;
    resp_en = 1'b1; rnd_delay = 1'b0; fixed_delay = dly;
    dskReadAddrInt = ai; dskReadAddrExt = ae;
    @(negedge clk); @(negedge clk);
    req_log.delete();
    _reset = 1'b1;
  endtask

  task automatic test_reset();
    _reset = 1'b0;
    #1;
    n_checks++;
    if (memReq !== 1'b0) begin n_fail++; $display("FAIL reset_memReq got %b want 0", memReq); end
    n_checks++;
    if (memAddr !== 24'h0) begin n_fail++; $display("FAIL reset_memAddr got %h want 000000", memAddr); end
    n_checks++;
    if (dskReadData !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", dskReadData); end
    n_checks++;
    if ({dskReadAckInt, dskReadAckExt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_acks got %b want 00", {dskReadAckInt, dskReadAckExt});
    end
  endtask

  task automatic test_int_fetch();
    int k, c;
    logic [7:0] d;
    start(22'h000000, 22'h000005, 0);
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 1 || d !== 8'hA5) begin n_fail++; $display("FAIL first_int_ack got kind=%0d data=%h want kind=1 data=a5", k, d); end
    n_checks++;
    if (req_log.size() != 1 || req_log[0] !== 24'h000000) begin
      n_fail++; $display("FAIL first_int_memAddr got n=%0d want n=1 addr=000000", req_log.size());
    end
    @(negedge clk);
    n_checks++;
    if ({dskReadAckInt, dskReadAckExt} !== 2'b00) begin
      n_fail++; $display("FAIL ack_one_cycle got %b want 00", {dskReadAckInt, dskReadAckExt});
    end
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 2 || d !== 8'h34) begin n_fail++; $display("FAIL ext_ack got kind=%0d data=%h want kind=2 data=34", k, d); end
    n_checks++;
    if (req_log.size() != 2 || req_log[1] !== 24'h100002) begin
      n_fail++; $display("FAIL ext_memAddr got n=%0d want n=2 addr=100002", req_log.size());
    end
    @(negedge clk);
    #2 inject = 1'b1;
    wait_ack(6, k, d, c);
    n_checks++;
    if (k !== 0) begin n_fail++; $display("FAIL stray_memAck_or_repeat got kind=%0d want 0", k); end
    dskReadAddrInt = 22'h000001;
    wait_ack(6, k, d, c);
    n_checks++;
    if (k !== 1 || d !== 8'hC3 || c !== 1) begin
      n_fail++; $display("FAIL int_hit got kind=%0d data=%h cyc=%0d want kind=1 data=c3 cyc=1", k, d, c);
    end
    n_checks++;
    if (req_log.size() != 2) begin n_fail++; $display("FAIL int_hit_no_req got n=%0d want 2", req_log.size()); end
    @(negedge clk);
    dskReadAddrInt = 22'h000002;
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 1 || d !== exp_byte(0, 22'h000002)) begin
      n_fail++; $display("FAIL int_miss2 got kind=%0d data=%h want kind=1 data=%h", k, d, exp_byte(0, 22'h000002));
    end
    n_checks++;
    if (req_log.size() != 3 || req_log[2] !== 24'h000001) begin
      n_fail++; $display("FAIL int_miss2_memAddr got n=%0d want n=3 addr=000001", req_log.size());
    end
  endtask

  task automatic test_change_during_fetch();
    int k, c;
    logic [7:0] d;
    bit stable;
    start(22'h000040, 22'h000041, 5);
    for (int i = 0; i < 10 && !memReq; i++) @(negedge clk);
    dskReadAddrInt = 22'h000080;
    stable = 1'b1;
    for (int i = 0; i < 10 && memReq && !memAck; i++) begin
      if (memAddr !== 24'h000020) stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL req_addr_stable got %h want 000020", memAddr); end
    wait_ack(30, k, d, c);
    n_checks++;
    if (k !== 1 || d !== exp_byte(0, 22'h000040)) begin
      n_fail++; $display("FAIL change_old_byte got kind=%0d data=%h want kind=1 data=%h", k, d, exp_byte(0, 22'h000040));
    end
    wait_ack(30, k, d, c);
    n_checks++;
    if (k !== 2 || d !== exp_byte(1, 22'h000041)) begin
      n_fail++; $display("FAIL change_ext_turn got kind=%0d data=%h want kind=2 data=%h", k, d, exp_byte(1, 22'h000041));
    end
    wait_ack(30, k, d, c);
    n_checks++;
    if (k !== 1 || d !== exp_byte(0, 22'h000080)) begin
      n_fail++; $display("FAIL change_new_byte got kind=%0d data=%h want kind=1 data=%h", k, d, exp_byte(0, 22'h000080));
    end
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 0 || req_log.size() != 3) begin
      n_fail++; $display("FAIL change_no_dup got kind=%0d reqs=%0d want kind=0 reqs=3", k, req_log.size());
    end
  endtask

  task automatic test_reset_midfetch();
    int k, c, n0;
    logic [7:0] d;
    start(22'h000010, 22'h000300, 0);
    wait_ack(20, k, d, c);
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 2 || d !== exp_byte(1, 22'h000300)) begin
      n_fail++; $display("FAIL pre_reset_ext got kind=%0d data=%h want kind=2 data=%h", k, d, exp_byte(1, 22'h000300));
    end
    resp_en = 1'b0;
    @(negedge clk);
    dskReadAddrInt = 22'h000020;
    for (int i = 0; i < 10 && !memReq; i++) @(negedge clk);
    #2 _reset = 1'b0;
    #1;
    n_checks++;
    if (memReq !== 1'b0) begin n_fail++; $display("FAIL async_reset_memReq got %b want 0", memReq); end
    inject = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dskReadAckInt, dskReadAckExt} !== 2'b00) begin
      n_fail++; $display("FAIL ack_in_reset got %b want 00", {dskReadAckInt, dskReadAckExt});
    end
    @(negedge clk);
    dskReadAddrInt = 22'h000011;
    n0 = req_log.size();
    resp_en = 1'b1;
    _reset = 1'b1;
    wait_ack(20, k, d, c);
    n_checks++;
    if (k !== 1 || d !== exp_byte(0, 22'h000011)) begin
      n_fail++; $display("FAIL post_reset_int got kind=%0d data=%h want kind=1 data=%h", k, d, exp_byte(0, 22'h000011));
    end
    n_checks++;
    if (req_log.size() != n0 + 1 || req_log[n0] !== 24'h000008) begin
      n_fail++; $display("FAIL post_reset_refetch got n=%0d want n=%0d addr=000008", req_log.size(), n0 + 1);
    end
    wait_ack(20, k, d, c);
  endtask

  // Both drives always re-pending: grants must alternate, the byte must match
  // the image, and memory is read only when the drive's buffered word differs.
  task automatic test_back_to_back();
    int k, c, exp_sel, nseen;
    logic [7:0] d;
    logic [21:0] cur[2];
    bit bv[2];
    logic [20:0] bw[2];
    bit miss;
    cur[0] = 22'($urandom); cur[1] = 22'($urandom);
    bv[0] = 1'b0; bv[1] = 1'b0; bw[0] = '0; bw[1] = '0;
    start(cur[0], cur[1], 0);
    rnd_delay = 1'b1;
    exp_sel = 0; nseen = 0;
    for (int it = 0; it < 40; it++) begin
      wait_ack(40, k, d, c);
      n_checks++;
      if (k !== exp_sel + 1) begin
        n_fail++; $display("FAIL rr_order it=%0d got kind=%0d want %0d", it, k, exp_sel + 1);
        break;
      end
      n_checks++;
      if (d !== exp_byte(exp_sel, cur[exp_sel])) begin
        n_fail++; $display("FAIL rr_data it=%0d got %h want %h", it, d, exp_byte(exp_sel, cur[exp_sel]));
      end
      miss = !bv[exp_sel] || bw[exp_sel] != cur[exp_sel][21:1];
      n_checks++;
      if (miss) begin
        if (req_log.size() != nseen + 1 || req_log[nseen] !== word_addr(exp_sel, cur[exp_sel])) begin
          n_fail++; $display("FAIL rr_miss_req it=%0d got n=%0d want n=%0d addr=%h", it, req_log.size(), nseen + 1,
                             word_addr(exp_sel, cur[exp_sel]));
        end
        nseen++;
        bv[exp_sel] = 1'b1; bw[exp_sel] = cur[exp_sel][21:1];
      end else if (req_log.size() != nseen) begin
        n_fail++; $display("FAIL rr_hit_req it=%0d got n=%0d want n=%0d", it, req_log.size(), nseen);
      end
      case ($urandom_range(0, 3))
        0, 1: cur[exp_sel] = cur[exp_sel] + 22'd1;
        2:    cur[exp_sel] = cur[exp_sel] ^ 22'd1;
        default: cur[exp_sel] = 22'($urandom);
      endcase
      if (exp_sel == 0) dskReadAddrInt = cur[0]; else dskReadAddrExt = cur[1];
      exp_sel ^= 1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    resp_en = 1'b0; rnd_delay = 1'b0; fixed_delay = 0; inject = 1'b0;
    _reset = 1'b0;
    dskReadAddrInt = '0; dskReadAddrExt = '0;
    test_reset();
    test_int_fetch();
    test_change_during_fetch();
    test_reset_midfetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
